pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Parametrised successor to the single-cycle main decoder.
- Decodes the ID-stage opcode into a control bundle, then carries that bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards (stall) and applies branch flushes.
- Optionally decodes JAL, JALR and LUI; counts illegal opcodes in hardware instead of printing them.

Parameters:
REG_ADDR_W, 5, width of rs1/rs2/rd register addresses
SUPPORT_JUMP, 1, 1 = decode JAL/JALR/LUI; 0 = treat them as illegal
ILL_CNT_W, 8, width of the saturating illegal-opcode counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
opcode  in  7  instruction[6:0] in ID
rs1  in  REG_ADDR_W  source register 1 address in ID
rs2  in  REG_ADDR_W  source register 2 address in ID
rd  in  REG_ADDR_W  destination register address in ID
flush  in  1  branch/jump taken in EX; kill the ID instruction
stall  out  1  load-use hazard; upstream holds PC and IF/ID
ex_valid  out  1  EX stage holds a real instruction
ex_ctrl  out  9  {ALUOp[1:0], Jump, Branch, ALUSrc, MemToReg, MemWrite, MemRead, RegWrite} (bit 0 = RegWrite)
ex_rd  out  REG_ADDR_W  destination register in EX
mem_ctrl  out  4  {MemToReg, MemWrite, MemRead, RegWrite}
mem_rd  out  REG_ADDR_W  destination register in MEM
wb_ctrl  out  2  {MemToReg, RegWrite}
wb_rd  out  REG_ADDR_W  destination register in WB
illegal_seen  out  1  sticky illegal-opcode flag
illegal_count  out  ILL_CNT_W  saturating count of illegal opcodes

Behaviour:
Reset:
- rst high clears every register immediately (asynchronous): ex_valid, ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd, illegal_seen and illegal_count all go to 0.
- stall is combinational and therefore also reads 0 while reset is held.
- Reset mid-stream discards all in-flight control.

Decode (combinational), flags set / ALUOp / sources read:
- R-type 0110011: RegWrite / 10 / rs1, rs2.
- OP-IMM 0010011: ALUSrc, RegWrite / 10 / rs1.
- Load 0000011: ALUSrc, MemToReg, RegWrite, MemRead / 00 / rs1.
- Store 0100011: ALUSrc, MemWrite / 00 / rs1, rs2.
- Branch 1100011: Branch / 11 / rs1, rs2.
- SUPPORT_JUMP=1 only:
  - JAL 1101111: Jump, RegWrite / 00 / none.
  - JALR 1100111: Jump, ALUSrc, RegWrite / 00 / rs1.
  - LUI 0110111: ALUSrc, RegWrite / 00 / none.
- Any other opcode is illegal: all-zero control, no sources read.
- RegWrite is forced to 0 when rd == 0; x0 writes never reach WB.

Hazard detection:
- stall = id_valid & ex_valid & ex_ctrl.MemRead & (ex_rd != 0) & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
- stall is forced to 0 when flush = 1.

ID/EX update, each edge, first match wins:
- flush = 1: bubble (ex_valid = 0, ex_ctrl = 0, ex_rd = 0).
- stall = 1: bubble, same as above.
- id_valid = 0: bubble.
- Otherwise: load the decoded bundle, ex_rd = rd, ex_valid = 1.

EX/MEM and MEM/WB:
- Advance unconditionally every cycle; never stalled.
- mem_ctrl/mem_rd take the relevant fields of ex_ctrl/ex_rd.
- wb_ctrl/wb_rd take the relevant fields of mem_ctrl/mem_rd.
- Latency: an instruction's decode appears on ex_* 1 cycle after acceptance, on mem_* after 2 cycles, on wb_* after 3 cycles.

Illegal tracking:
- Counted only when an illegal opcode would otherwise be loaded into ID/EX (id_valid = 1, flush = 0, stall = 0).
- That instruction enters EX as ex_valid = 1 with all-zero ex_ctrl.
- illegal_seen sets and stays set until reset.
- illegal_count increments and saturates at all-ones; it never wraps.
- No simulation-only messages.

Simultaneous events:
- flush and a hazard in the same cycle: flush wins, stall = 0, one bubble is inserted.
- A stalled instruction re-presents the next cycle. Because a bubble is now in EX, stall deasserts and the instruction is accepted.
- Exactly one bubble is inserted per load-use hazard.

Test Plan:
1. Reset mid-stream, with all three stages holding control, assert rst between clock edges -> every output reads 0 immediately, before the next edge.
2. Issue lw x5, then add x6,x5,x7 -> stall = 1 for one cycle, then ex_valid = 0 for one cycle, then the add reaches EX with ex_ctrl = 9'b10_0000001. wb_ctrl for the lw = 2'b11 three cycles after its acceptance.
3. lw x5 followed by a store using rs2 = x5 -> stall. lw x0 followed by add using x0 -> no stall, and the lw's RegWrite = 0 in ex_ctrl.
4. Assert flush with a hazard pending -> stall = 0, a bubble enters EX, and illegal_count is unchanged even if the killed opcode is illegal.
5. SUPPORT_JUMP=0: a JAL opcode gives illegal_seen = 1, illegal_count = 1 and ex_ctrl = 0. SUPPORT_JUMP=1: JAL with rd = 1 gives ex_ctrl = 9'b00_1000001.
6. Feed 260 illegal opcodes with ILL_CNT_W = 8 -> illegal_count holds at 255 and does not wrap.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Pipelined main decoder: decodes the ID opcode into a control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB, with load-use stall, flush and illegal-opcode tracking.
module pipelined_control_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter bit SUPPORT_JUMP = 1'b1,
  parameter int ILL_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [8:0]            ex_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [3:0]            mem_ctrl,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [1:0]            wb_ctrl,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  illegal_seen,
  output logic [ILL_CNT_W-1:0]  illegal_count
);

  logic [1:0] alu_op;
  logic       jump, branch, alu_src, mem_to_reg, mem_write, mem_read, reg_write;
  logic       uses_rs1, uses_rs2, illegal;
  logic [8:0] dec_ctrl;
  logic       accept;

  always_comb begin
    alu_op     = 2'b00;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    reg_write  = 1'b0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      7'b0110011: begin alu_op = 2'b10; reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011: begin alu_op = 2'b10; alu_src = 1'b1; reg_write = 1'b1; uses_rs1 = 1'b1; end
      7'b0000011: begin
        alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; mem_read = 1'b1; uses_rs1 = 1'b1;
      end
      7'b0100011: begin alu_src = 1'b1; mem_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin alu_op = 2'b11; branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1101111: begin
        if (SUPPORT_JUMP) begin jump = 1'b1; reg_write = 1'b1; end
        else illegal = 1'b1;
      end
      7'b1100111: begin
        if (SUPPORT_JUMP) begin jump = 1'b1; alu_src = 1'b1; reg_write = 1'b1; uses_rs1 = 1'b1; end
        else illegal = 1'b1;
      end
      7'b0110111: begin
        if (SUPPORT_JUMP) begin alu_src = 1'b1; reg_write = 1'b1; end
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // x0 is never a real write target, so RegWrite is dropped at decode.
  assign dec_ctrl = {alu_op, jump, branch, alu_src, mem_to_reg, mem_write, mem_read,
                     reg_write && (rd != '0)};

  assign stall = !flush && id_valid && ex_valid && ex_ctrl[1] && (ex_rd != '0) &&
                 ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

  assign accept = id_valid && !flush && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= dec_ctrl;
      ex_rd    <= rd;
    end else begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ctrl <= '0;
      mem_rd   <= '0;
      wb_ctrl  <= '0;
      wb_rd    <= '0;
    end else begin
      mem_ctrl <= ex_ctrl[3:0];
      mem_rd   <= ex_rd;
      wb_ctrl  <= {mem_ctrl[3], mem_ctrl[0]};
      wb_rd    <= mem_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen  <= 1'b0;
      illegal_count <= '0;
    end else if (accept && illegal) begin
      illegal_seen <= 1'b1;
      if (illegal_count != '1) illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: decode table, directed hazard/flush/reset
// sequences, counter saturation, and randomized traffic against a queue-style reference model.
module tb_pipelined_control_unit;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0;
  logic [6:0]    opcode = '0;
  logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic          flush = 1'b0;

  logic          stall, ex_valid, illegal_seen;
  logic [8:0]    ex_ctrl;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [3:0]    mem_ctrl;
  logic [1:0]    wb_ctrl;
  logic [7:0]    illegal_count;

  logic          nj_stall, nj_ex_valid, nj_illegal_seen;
  logic [8:0]    nj_ex_ctrl;
  logic [AW-1:0] nj_ex_rd, nj_mem_rd, nj_wb_rd;
  logic [3:0]    nj_mem_ctrl;
  logic [1:0]    nj_wb_ctrl;
  logic [7:0]    nj_illegal_count;

  pipelined_control_unit #(.REG_ADDR_W(AW), .SUPPORT_JUMP(1'b1), .ILL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .rs1(rs1), .rs2(rs2),
    .rd(rd), .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
    .illegal_seen(illegal_seen), .illegal_count(illegal_count));

  pipelined_control_unit #(.REG_ADDR_W(AW), .SUPPORT_JUMP(1'b0), .ILL_CNT_W(8)) dut_nj (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .rs1(rs1), .rs2(rs2),
    .rd(rd), .flush(flush), .stall(nj_stall), .ex_valid(nj_ex_valid), .ex_ctrl(nj_ex_ctrl),
    .ex_rd(nj_ex_rd), .mem_ctrl(nj_mem_ctrl), .mem_rd(nj_mem_rd), .wb_ctrl(nj_wb_ctrl),
    .wb_rd(nj_wb_rd), .illegal_seen(nj_illegal_seen), .illegal_count(nj_illegal_count));

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] d, input logic f);
    id_valid = v; opcode = op; rs1 = a; rs2 = b; rd = d; flush = f;
  endtask

  task automatic do_reset();
    drive(1'b0, 7'h00, '0, '0, '0, 1'b0);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    tick();
  endtask

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  // ---------------- reference model ----------------
  logic [8:0]    m_ctrl [3];
  logic [AW-1:0] m_rd   [3];
  logic          m_v;
  int            m_cnt;

  task automatic ref_decode(input logic [6:0] op, input logic [AW-1:0] d,
                            output logic [8:0] c, output logic u1, output logic u2,
                            output logic ill);
    logic [1:0] alu;
    logic j, br, src, m2r, mw, mr, rw;
    {alu, j, br, src, m2r, mw, mr, rw} = '0;
    u1 = 0; u2 = 0; ill = 0;
    if (op == OP_R)         begin alu = 2; rw = 1; u1 = 1; u2 = 1; end
    else if (op == OP_I)    begin alu = 2; src = 1; rw = 1; u1 = 1; end
    else if (op == OP_LD)   begin src = 1; m2r = 1; rw = 1; mr = 1; u1 = 1; end
    else if (op == OP_ST)   begin src = 1; mw = 1; u1 = 1; u2 = 1; end
    else if (op == OP_BR)   begin alu = 3; br = 1; u1 = 1; u2 = 1; end
    else if (op == OP_JAL)  begin j = 1; rw = 1; end
    else if (op == OP_JALR) begin j = 1; src = 1; rw = 1; u1 = 1; end
    else if (op == OP_LUI)  begin src = 1; rw = 1; end
    else ill = 1;
    if (d == 0) rw = 0;
    c = {alu, j, br, src, m2r, mw, mr, rw};
  endtask

  typedef struct {
    logic [6:0]    op;
    logic [AW-1:0] d;
    logic [8:0]    exp;
  } vec_t;

  vec_t vecs [11];
  logic [6:0] ops [8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{OP_R,    5'd3, 9'b10_0000001};
    vecs[1]  = '{OP_I,    5'd4, 9'b10_0010001};
    vecs[2]  = '{OP_LD,   5'd5, 9'b00_0011011};
    vecs[3]  = '{OP_ST,   5'd6, 9'b00_0010100};
    vecs[4]  = '{OP_BR,   5'd7, 9'b11_0100000};
    vecs[5]  = '{OP_JAL,  5'd1, 9'b00_1000001};
    vecs[6]  = '{OP_JALR, 5'd2, 9'b00_1010001};
    vecs[7]  = '{OP_LUI,  5'd8, 9'b00_0010001};
    vecs[8]  = '{OP_BAD,  5'd9, 9'b00_0000000};
    vecs[9]  = '{OP_R,    5'd0, 9'b10_0000000};
    vecs[10] = '{OP_LD,   5'd0, 9'b00_0011010};
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI};

    do_reset();
    chk("reset_ex_valid", 32'(ex_valid), 32'(0));
    chk("reset_count", 32'(illegal_count), 32'(0));

    // JAL with and without jump support
    drive(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1, 1'b0);
    tick();
    chk("jal_ctrl", 32'(ex_ctrl), 32'(9'b00_1000001));
    chk("nj_jal_ctrl", 32'(nj_ex_ctrl), 32'(0));
    chk("nj_jal_valid", 32'(nj_ex_valid), 32'(1));
    chk("nj_jal_seen", 32'(nj_illegal_seen), 32'(1));
    chk("nj_jal_count", 32'(nj_illegal_count), 32'(1));
    chk("jal_no_illegal", 32'(illegal_seen), 32'(0));

    // decode table
    do_reset();
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, 5'd20, 5'd21, vecs[i].d, 1'b0);
      tick();
      chk($sformatf("tbl%0d_ex_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].exp));
      chk($sformatf("tbl%0d_ex_valid", i), 32'(ex_valid), 32'(1));
      chk($sformatf("tbl%0d_ex_rd", i), 32'(ex_rd), 32'(vecs[i].d));
      drive(1'b0, 7'h00, '0, '0, '0, 1'b0);
      tick();
      chk($sformatf("tbl%0d_mem_ctrl", i), 32'(mem_ctrl), 32'(vecs[i].exp[3:0]));
      chk($sformatf("tbl%0d_bubble", i), 32'(ex_valid), 32'(0));
    end
    chk("tbl_illegal_count", 32'(illegal_count), 32'(1));

    // load-use: lw x5; add x6,x5,x7
    do_reset();
    drive(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6, 1'b0);
    #1 chk("lu_stall", 32'(stall), 32'(1));
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'(0));
    chk("lu_stall_drop", 32'(stall), 32'(0));
    chk("lu_lw_mem", 32'(mem_ctrl), 32'(4'b1011));
    tick();
    chk("lu_add_ctrl", 32'(ex_ctrl), 32'(9'b10_0000001));
    chk("lu_add_rd", 32'(ex_rd), 32'(6));
    chk("lu_lw_wb", 32'(wb_ctrl), 32'(2'b11));
    chk("lu_lw_wb_rd", 32'(wb_rd), 32'(5));

    // store rs2 hazard, then lw x0
    drive(1'b0, 7'h00, '0, '0, '0, 1'b0);
    tick(); tick();
    drive(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drive(1'b1, OP_ST, 5'd1, 5'd5, 5'd0, 1'b0);
    #1 chk("st_stall", 32'(stall), 32'(1));
    tick();
    tick();
    drive(1'b1, OP_LD, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    chk("lw_x0_ctrl", 32'(ex_ctrl), 32'(9'b00_0011010));
    drive(1'b1, OP_R, 5'd0, 5'd0, 5'd6, 1'b0);
    #1 chk("lw_x0_no_stall", 32'(stall), 32'(0));

    // flush with hazard pending; flushed illegal not counted
    drive(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd5, 5'd5, 5'd6, 1'b1);
    #1 chk("fl_stall", 32'(stall), 32'(0));
    tick();
    chk("fl_bubble", 32'(ex_valid), 32'(0));
    drive(1'b1, OP_BAD, 5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    chk("fl_ill_count", 32'(illegal_count), 32'(0));
    chk("fl_ill_seen", 32'(illegal_seen), 32'(0));

    // reset mid-stream with all stages occupied
    drive(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);  tick();
    drive(1'b1, OP_BAD, 5'd1, 5'd2, 5'd7, 1'b0); tick();
    drive(1'b1, OP_R, 5'd1, 5'd2, 5'd9, 1'b0);   tick();
    chk("pre_rst_wb", 32'(wb_ctrl), 32'(2'b11));
    drive(1'b1, OP_R, 5'd9, 5'd9, 5'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 32'({stall, ex_valid, ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd}),
        32'(0));
    chk("rst_async_ill", 32'({illegal_seen, illegal_count}), 32'(0));
    #3 rst = 1'b0;
    tick();

    // saturation of the illegal counter
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, OP_BAD, 5'd1, 5'd2, 5'd3, 1'b0);
      tick();
      if (i == 253) chk("sat_254", 32'(illegal_count), 32'(254));
      if (i == 254) chk("sat_255", 32'(illegal_count), 32'(255));
    end
    chk("sat_hold", 32'(illegal_count), 32'(255));
    chk("sat_seen", 32'(illegal_seen), 32'(1));

    // randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 3; k++) begin m_ctrl[k] = '0; m_rd[k] = '0; end
    m_v = 0; m_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      logic [6:0] op;
      logic [AW-1:0] a, b, d;
      logic v, f, u1, u2, ill, m_stall;
      logic [8:0] c;
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : ops[$urandom_range(0, 7)];
      a = AW'($urandom_range(0, 3)); b = AW'($urandom_range(0, 3)); d = AW'($urandom_range(0, 3));
      v = ($urandom_range(0, 7) != 0);
      f = ($urandom_range(0, 7) == 0);
      drive(v, op, a, b, d, f);
      ref_decode(op, d, c, u1, u2, ill);
      m_stall = !f && v && m_v && m_ctrl[0][1] && (m_rd[0] != 0) &&
                ((u1 && a == m_rd[0]) || (u2 && b == m_rd[0]));
      #1 chk("rnd_stall", 32'(stall), 32'(m_stall));
      m_ctrl[2] = m_ctrl[1]; m_rd[2] = m_rd[1];
      m_ctrl[1] = m_ctrl[0]; m_rd[1] = m_rd[0];
      if (v && !f && !m_stall) begin
        m_v = 1; m_ctrl[0] = c; m_rd[0] = d;
        if (ill && m_cnt < 255) m_cnt++;
      end else begin
        m_v = 0; m_ctrl[0] = '0; m_rd[0] = '0;
      end
      tick();
      chk("rnd_ex", 32'({ex_valid, ex_ctrl, ex_rd}), 32'({m_v, m_ctrl[0], m_rd[0]}));
      chk("rnd_mem", 32'({mem_ctrl, mem_rd}), 32'({m_ctrl[1][3:0], m_rd[1]}));
      chk("rnd_wb", 32'({wb_ctrl, wb_rd}), 32'({m_ctrl[2][3], m_ctrl[2][0], m_rd[2]}));
      chk("rnd_ill", 32'({illegal_seen, illegal_count}), 32'({m_cnt != 0, 8'(m_cnt)}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
